rhs2116_frame_deframer: RTL and testbench
=========================================

Name: rhs2116_frame_deframer

Overview:
Parametrised single-clock deframer for the RHS2116 coax receive path. It consumes the recovered bit stream (bit_in/bit_valid, already in the clk_sys domain) and hunts for a configurable sync word. It acquires and holds frame lock with hysteresis, tags each payload with a channel index from a superframe marker, and buffers words in an internal FIFO with ready/valid backpressure. It replaces the fixed 32-bit frame sync plus always-drained FIFO with a generalised width, depth and multichannel block.

Parameters:
DATA_WIDTH, 32, payload bits per frame
SYNC_WIDTH, 8, sync word bits
SYNC_PATTERN, 8'hA5, normal-frame sync; its bitwise inverse marks channel 0 (superframe start)
NUM_CHANNELS, 4, channels per superframe (>=1); CHAN_W = max(1, clog2(NUM_CHANNELS))
LOCK_COUNT, 3, consecutive good syncs needed to lock (>=1)
MISS_LIMIT, 2, consecutive bad syncs in LOCKED before lock is dropped (>=1)
FIFO_DEPTH, 8, output buffer entries (power of 2, >=2)

Ports:
clk_sys  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
bit_in  in  1  serial data, MSB first
bit_valid  in  1  bit_in qualifier; state frozen when low
out_data  out  DATA_WIDTH  payload word
out_chan  out  CHAN_W  channel tag
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accept; transfer when out_valid && out_ready
locked  out  1  high in LOCKED state
frame_error  out  1  1-cycle pulse: bad sync or parity in LOCKED
sync_lost  out  1  1-cycle pulse on LOCKED->HUNT
overflow  out  1  1-cycle pulse when a word is dropped because the FIFO is full
fifo_level  out  clog2(FIFO_DEPTH)+1  entries held

Behaviour:
- Reset: all outputs 0, state HUNT, counters 0, FIFO empty, channel counter 0. Reset mid-frame discards the partial frame.
- Frame format: SYNC_WIDTH sync bits, then DATA_WIDTH payload bits, then one parity bit if the macro is defined. Frame length is F.
- HUNT: each valid bit shifts into a SYNC_WIDTH register. A match against SYNC_PATTERN or ~SYNC_PATTERN latches the frame start.
  - If LOCK_COUNT==1: go to LOCKED. Otherwise: go to VERIFY with good_cnt=1.
- VERIFY/LOCKED: a bit counter tracks position in the frame. At each sync-field end, the received sync is compared.
  - VERIFY, good sync: good_cnt++. Reaching LOCK_COUNT moves to LOCKED, and this frame is the first one emitted.
  - VERIFY, bad sync: return to HUNT. No pulses.
  - LOCKED, good sync: miss_cnt=0.
  - LOCKED, bad sync: frame_error pulse, miss_cnt++, payload of that frame discarded, bit counter keeps framing. When miss_cnt reaches MISS_LIMIT: sync_lost pulse, locked falls the next cycle, enter HUNT.
- Channel: ~SYNC_PATTERN sync sets chan=0. SYNC_PATTERN sync sets chan=(prev+1) mod NUM_CHANNELS. Discarded frames still advance chan.
- Emit: in LOCKED with a good sync, after the last frame bit (payload or parity) is accepted, {payload, chan} is written to the FIFO on the next cycle. Latency from last bit to out_valid, with the FIFO empty, is 2 cycles.
- FIFO: first-word-fall-through. out_data/out_chan are stable while out_valid && !out_ready.
  - Simultaneous write and read when full: allowed, no overflow.
  - Write when full without a read: word dropped, overflow pulse.
  - Pointers wrap modulo FIFO_DEPTH.
- The FIFO keeps draining regardless of lock state.

Optional Feature:
Macro: RHS2116_DEFRAMER_PARITY_EN.
- Defined: each frame carries one trailing even-parity bit covering payload plus parity. In LOCKED, a parity failure with a good sync gives a frame_error pulse and the word is dropped. It does not count toward miss_cnt. In VERIFY, parity is ignored.
- Undefined: no parity bit, F=SYNC_WIDTH+DATA_WIDTH, no parity logic.

Test Plan:
Defaults, macro undefined unless stated.
- Acquire: 0x3C garbage bits, then ~A5/0x00000000, A5/0x11111111, A5/0x22222222, A5/0x33333333 -> locked rises during frame 3. Outputs are (0x22222222, chan 2) then (0x33333333, chan 3). Nothing from frames 1-2.
- Loss: locked stream, then a single frame with sync 0xA4 -> one frame_error, payload dropped, lock held. Two consecutive 0xA4 frames -> two frame_error, sync_lost pulse, locked=0.
- Backpressure: out_ready=0 with 10 good frames after lock -> fifo_level=8, two overflow pulses. Then out_ready=1 -> the 8 oldest words are read in order.
- Full plus simultaneous read: FIFO at 8, out_ready=1 in the cycle a word is written -> level stays 8, no overflow.
- Reset mid-frame: rst_n low for 1 cycle after 20 bits of a locked frame -> all outputs 0 immediately. The next 3 good frames are required to relock.
- Parity (macro defined): locked stream with payload 0x00000001 and parity bit 0 -> frame_error pulse, no output, locked stays 1.

Source files
------------

// File: rtl/rhs2116_frame_deframer.sv
// RHS2116 coax deframer: sync hunt, lock hysteresis, superframe channel tagging, FWFT output FIFO.
// Define RHS2116_DEFRAMER_PARITY_EN to expect a trailing even-parity bit on every frame.
module rhs2116_frame_deframer #(
    parameter int DATA_WIDTH                   = 32,
    parameter int SYNC_WIDTH                   = 8,
    parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN = 8'hA5,
    parameter int NUM_CHANNELS                 = 4,
    parameter int LOCK_COUNT                   = 3,
    parameter int MISS_LIMIT                   = 2,
    parameter int FIFO_DEPTH                   = 8,
    localparam int CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CHAN_W-1:0]     out_chan,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  locked,
    output logic                  frame_error,
    output logic                  sync_lost,
    output logic                  overflow,
    output logic [LVL_W-1:0]      fifo_level
);

`ifdef RHS2116_DEFRAMER_PARITY_EN
    localparam int FRAME_LEN = SYNC_WIDTH + DATA_WIDTH + 1;
`else
    localparam int FRAME_LEN = SYNC_WIDTH + DATA_WIDTH;
`endif
    localparam int BC_W = $clog2(FRAME_LEN);
    localparam int GC_W = $clog2(LOCK_COUNT + 1);
    localparam int MC_W = $clog2(MISS_LIMIT + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam logic [SYNC_WIDTH-1:0] SYNC_INV = ~SYNC_PATTERN;
    localparam logic [CHAN_W-1:0]     CHAN_MAX = CHAN_W'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t                  state, state_nxt;
    logic [SYNC_WIDTH-1:0]   sync_sr, sync_win;
    logic [DATA_WIDTH-1:0]   data_sr, word;
    logic [BC_W-1:0]         bit_cnt, bit_cnt_nxt;
    logic [GC_W-1:0]         good_cnt, good_cnt_nxt;
    logic [MC_W-1:0]         miss_cnt, miss_cnt_nxt;
    logic [CHAN_W-1:0]       chan, chan_nxt, chan_adv, chan_sync;
    logic                    frame_ok, frame_ok_nxt;
    logic                    emit_nxt, ferr_nxt, slost_nxt;
    logic                    sync_norm, sync_sup, sync_good, sync_end, frame_end, word_ok;
    logic                    emit_q;
    logic [DATA_WIDTH-1:0]   emit_data;
    logic [CHAN_W-1:0]       emit_chan;

    assign sync_win  = {sync_sr[SYNC_WIDTH-2:0], bit_in};
    assign sync_norm = (sync_win == SYNC_PATTERN);
    assign sync_sup  = (sync_win == SYNC_INV);
    assign sync_good = sync_norm | sync_sup;
    assign sync_end  = (bit_cnt == BC_W'(SYNC_WIDTH - 1));
    assign frame_end = (bit_cnt == BC_W'(FRAME_LEN - 1));
    assign chan_adv  = (chan == CHAN_MAX) ? '0 : chan + 1'b1;
    assign chan_sync = sync_sup ? '0 : chan_adv;
    assign locked    = (state == LOCKED);

`ifdef RHS2116_DEFRAMER_PARITY_EN
    // Parity bit is the bit on the wire now; the payload is already fully shifted in.
    assign word    = data_sr;
    assign word_ok = ~^{data_sr, bit_in};
`else
    assign word    = {data_sr[DATA_WIDTH-2:0], bit_in};
    assign word_ok = 1'b1;
`endif

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        good_cnt_nxt = good_cnt;
        miss_cnt_nxt = miss_cnt;
        chan_nxt     = chan;
        frame_ok_nxt = frame_ok;
        emit_nxt     = 1'b0;
        ferr_nxt     = 1'b0;
        slost_nxt    = 1'b0;
        if (bit_valid) begin
            case (state)
                HUNT: if (sync_good) begin
                    chan_nxt     = chan_sync;
                    bit_cnt_nxt  = BC_W'(SYNC_WIDTH);
                    miss_cnt_nxt = '0;
                    if (LOCK_COUNT == 1) begin
                        state_nxt    = LOCKED;
                        good_cnt_nxt = '0;
                        frame_ok_nxt = 1'b1;
                    end else begin
                        state_nxt    = VERIFY;
                        good_cnt_nxt = GC_W'(1);
                        frame_ok_nxt = 1'b0;
                    end
                end
                VERIFY: begin
                    bit_cnt_nxt = frame_end ? '0 : bit_cnt + 1'b1;
                    if (sync_end) begin
                        if (sync_good) begin
                            chan_nxt = chan_sync;
                            if (int'(good_cnt) + 1 >= LOCK_COUNT) begin
                                state_nxt    = LOCKED;
                                good_cnt_nxt = '0;
                                frame_ok_nxt = 1'b1;
                            end else begin
                                good_cnt_nxt = good_cnt + 1'b1;
                            end
                        end else begin
                            state_nxt    = HUNT;
                            good_cnt_nxt = '0;
                        end
                    end
                end
                LOCKED: begin
                    bit_cnt_nxt = frame_end ? '0 : bit_cnt + 1'b1;
                    if (sync_end) begin
                        if (sync_good) begin
                            chan_nxt     = chan_sync;
                            miss_cnt_nxt = '0;
                            frame_ok_nxt = 1'b1;
                        end else begin
                            // Bad frames still occupy a channel slot.
                            chan_nxt     = chan_adv;
                            frame_ok_nxt = 1'b0;
                            ferr_nxt     = 1'b1;
                            if (int'(miss_cnt) + 1 >= MISS_LIMIT) begin
                                state_nxt    = HUNT;
                                slost_nxt    = 1'b1;
                                miss_cnt_nxt = '0;
                            end else begin
                                miss_cnt_nxt = miss_cnt + 1'b1;
                            end
                        end
                    end
                    if (frame_end && frame_ok) begin
                        emit_nxt = word_ok;
                        ferr_nxt = ~word_ok;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            sync_sr     <= '0;
            data_sr     <= '0;
            bit_cnt     <= '0;
            good_cnt    <= '0;
            miss_cnt    <= '0;
            chan        <= '0;
            frame_ok    <= 1'b0;
            frame_error <= 1'b0;
            sync_lost   <= 1'b0;
            emit_q      <= 1'b0;
            emit_data   <= '0;
            emit_chan   <= '0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            good_cnt    <= good_cnt_nxt;
            miss_cnt    <= miss_cnt_nxt;
            chan        <= chan_nxt;
            frame_ok    <= frame_ok_nxt;
            frame_error <= ferr_nxt;
            sync_lost   <= slost_nxt;
            emit_q      <= emit_nxt;
            if (bit_valid) begin
                sync_sr <= sync_win;
                data_sr <= {data_sr[DATA_WIDTH-2:0], bit_in};
            end
            if (emit_nxt) begin
                emit_data <= word;
                emit_chan <= chan;
            end
        end
    end

    // First-word-fall-through buffer; a push into a full FIFO is accepted only alongside a pop.
    logic [DATA_WIDTH+CHAN_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]                wr_ptr, rd_ptr;
    logic [LVL_W-1:0]             count;
    logic                         full, pop, push;

    assign full       = (count == LVL_W'(FIFO_DEPTH));
    assign out_valid  = (count != '0);
    assign pop        = out_valid && out_ready;
    assign push       = emit_q && (!full || pop);
    assign fifo_level = count;
    assign {out_data, out_chan} = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr] <= {emit_data, emit_chan};
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= emit_q && full && !pop;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_rhs2116_frame_deframer.sv
// Directed bench for rhs2116_frame_deframer: frame table plus reset, backpressure and full-FIFO sequences.
module tb_rhs2116_frame_deframer;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b1;
    logic        bit_in  = 1'b0;
    logic        bit_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [1:0]  out_chan;
    logic        out_valid, locked, frame_error, sync_lost, overflow;
    logic [3:0]  fifo_level;

    rhs2116_frame_deframer dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
        .locked(locked), .frame_error(frame_error), .sync_lost(sync_lost),
        .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk_sys = ~clk_sys;

    int vectors = 0;
    int miscompares = 0;
    int ferr_n = 0, slost_n = 0, ovf_n = 0;
    logic [33:0] rx_q[$];

    // Mid-cycle monitor: a word is taken whenever the next edge will transfer it.
    always @(negedge clk_sys) begin
        if (rst_n) begin
            if (out_valid && out_ready) rx_q.push_back({out_data, out_chan});
            if (frame_error) ferr_n++;
            if (sync_lost)   slost_n++;
            if (overflow)    ovf_n++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_in = b;
        bit_valid = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        bit_in = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] s, input logic [31:0] p, input bit par_flip, input bit ready_on_write);
        for (int i = 7; i >= 0; i--) send_bit(s[i]);
        for (int i = 31; i >= 0; i--) begin
            send_bit(p[i]);
            if (i == 28) idle(1);
        end
`ifdef RHS2116_DEFRAMER_PARITY_EN
        send_bit((^p) ^ par_flip);
`else
        if (par_flip) idle(0);
`endif
        if (ready_on_write) begin
            bit_valid = 1'b0;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic apply_reset();
        bit_valid = 1'b0;
        out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [7:0]  sync;
        logic [31:0] payload;
        logic        exp_locked;
        logic        exp_out;
        logic [1:0]  exp_chan;
        int          exp_ferr;
        int          exp_slost;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int fb, sb, ob, rb;
        tbl[0] = '{8'h5A, 32'h00000000, 1'b0, 1'b0, 2'd0, 0, 0};
        tbl[1] = '{8'hA5, 32'h11111111, 1'b0, 1'b0, 2'd1, 0, 0};
        tbl[2] = '{8'hA5, 32'h22222222, 1'b1, 1'b1, 2'd2, 0, 0};
        tbl[3] = '{8'hA5, 32'h33333333, 1'b1, 1'b1, 2'd3, 0, 0};
        tbl[4] = '{8'hA5, 32'h44444444, 1'b1, 1'b1, 2'd0, 0, 0};
        tbl[5] = '{8'hA4, 32'h55555555, 1'b1, 1'b0, 2'd1, 1, 0};
        tbl[6] = '{8'hA5, 32'h66666666, 1'b1, 1'b1, 2'd2, 0, 0};
        tbl[7] = '{8'h5A, 32'h77777777, 1'b1, 1'b1, 2'd0, 0, 0};
        tbl[8] = '{8'hA4, 32'h88888888, 1'b1, 1'b0, 2'd1, 1, 0};
        tbl[9] = '{8'hA4, 32'h99999999, 1'b0, 1'b0, 2'd2, 1, 1};

        // Reset state, checked while reset is held.
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_locked", locked, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_pulses", {frame_error, sync_lost, overflow}, 0);
        chk("rst_out_chan", out_chan, 0);
        repeat (2) @(posedge clk_sys);
        #1 rst_n = 1'b1;
        tick();

        // Acquisition: garbage with no sync pattern inside, then the frame table.
        for (int i = 0; i < 60; i++) send_bit(i % 4 == 0);
        chk("garbage_locked", locked, 0);
        for (int i = 0; i < 10; i++) begin
            fb = ferr_n; sb = slost_n; rb = rx_q.size();
            send_frame(tbl[i].sync, tbl[i].payload, 1'b0, 1'b0);
            idle(3);
            chk($sformatf("v%0d_locked", i), locked, tbl[i].exp_locked);
            chk($sformatf("v%0d_frame_error", i), ferr_n - fb, tbl[i].exp_ferr);
            chk($sformatf("v%0d_sync_lost", i), slost_n - sb, tbl[i].exp_slost);
            chk($sformatf("v%0d_words", i), rx_q.size() - rb, tbl[i].exp_out);
            if (tbl[i].exp_out && rx_q.size() > rb)
                chk($sformatf("v%0d_word", i), rx_q[rx_q.size()-1], {tbl[i].payload, tbl[i].exp_chan});
        end

        // Reset in the middle of a locked frame with a word waiting in the FIFO.
        apply_reset();
        out_ready = 1'b0;
        send_frame(8'h5A, 32'h0, 1'b0, 1'b0);
        send_frame(8'hA5, 32'h1, 1'b0, 1'b0);
        send_frame(8'hA5, 32'h2, 1'b0, 1'b0);
        idle(3);
        chk("pre_rst_level", fifo_level, 1);
        for (int i = 7; i >= 0; i--) send_bit(tbl[2].sync[i]);
        for (int i = 0; i < 12; i++) send_bit(1'b0);
        bit_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_level", fifo_level, 0);
        chk("midrst_locked", locked, 0);
        chk("midrst_out_data", out_data, 0);
        @(posedge clk_sys);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        rb = rx_q.size();
        send_frame(8'h5A, 32'hD0000000, 1'b0, 1'b0);
        send_frame(8'hA5, 32'hD0000001, 1'b0, 1'b0);
        idle(3);
        chk("relock_after2", locked, 0);
        send_frame(8'hA5, 32'hD0000002, 1'b0, 1'b0);
        idle(3);
        chk("relock_after3", locked, 1);
        chk("relock_words", rx_q.size() - rb, 1);
        if (rx_q.size() > rb) chk("relock_word", rx_q[rx_q.size()-1], {32'hD0000002, 2'd2});

        // Backpressure: 10 frames into an 8-deep FIFO.
        out_ready = 1'b0;
        ob = ovf_n;
        for (int i = 0; i < 10; i++) send_frame(8'hA5, 32'hB0000000 + i, 1'b0, 1'b0);
        idle(3);
        chk("bp_level", fifo_level, 8);
        chk("bp_overflow", ovf_n - ob, 2);
        chk("bp_head", {out_data, out_chan}, {32'hB0000000, 2'd3});
        rb = rx_q.size();
        out_ready = 1'b1;
        idle(10);
        chk("bp_drained", rx_q.size() - rb, 8);
        chk("bp_level_empty", fifo_level, 0);
        for (int k = 0; k < 8; k++)
            if (rx_q.size() > rb + k)
                chk($sformatf("bp_word%0d", k), rx_q[rb+k], {32'hB0000000 + k, 2'((3 + k) % 4)});

        // Full FIFO with a read in the same cycle as the write.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_frame(8'hA5, 32'hC0000000 + i, 1'b0, 1'b0);
        idle(3);
        chk("full_level", fifo_level, 8);
        ob = ovf_n;
        rb = rx_q.size();
        send_frame(8'hA5, 32'hC0000008, 1'b0, 1'b1);
        idle(2);
        chk("full_rw_level", fifo_level, 8);
        chk("full_rw_overflow", ovf_n - ob, 0);
        chk("full_rw_pop", rx_q.size() - rb, 1);
        if (rx_q.size() > rb) chk("full_rw_word", rx_q[rb], {32'hC0000000, 2'd1});
        out_ready = 1'b1;
        idle(12);
        chk("full_drained", rx_q.size() - rb, 9);
        if (rx_q.size() >= rb + 9) begin
            chk("full_first", rx_q[rb+1], {32'hC0000001, 2'd2});
            chk("full_last", rx_q[rb+8], {32'hC0000008, 2'd1});
        end

`ifdef RHS2116_DEFRAMER_PARITY_EN
        apply_reset();
        send_frame(8'h5A, 32'h0, 1'b0, 1'b0);
        send_frame(8'hA5, 32'h1, 1'b0, 1'b0);
        send_frame(8'hA5, 32'h2, 1'b0, 1'b0);
        idle(3);
        fb = ferr_n; rb = rx_q.size();
        send_frame(8'hA5, 32'h00000001, 1'b1, 1'b0);
        idle(3);
        chk("par_frame_error", ferr_n - fb, 1);
        chk("par_words", rx_q.size() - rb, 0);
        chk("par_locked", locked, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
